// File: rtl/pipe_mips.sv
// Five-stage in-order MIPS-like core (IF/ID/EX/MEM/WB) with a unified 1024-word memory
// and a 32-entry register file. It forwards into EX, resolves branches in EX, and freezes once HLT retires.
module pipe_mips (
  input  logic       clk,
  input  logic       rst_n,
  output logic       halted,
  output logic [9:0] pc
);

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000, OP_SUB  = 6'b000001, OP_AND  = 6'b000010,
    OP_OR    = 6'b000011, OP_SLT  = 6'b000100, OP_MUL  = 6'b000101,
    OP_LW    = 6'b001000, OP_SW   = 6'b001001, OP_ADDI = 6'b001010,
    OP_SUBI  = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110, OP_NOP  = 6'b110000, OP_HLT  = 6'b111111
  } opcode_e;

  typedef enum logic [2:0] {K_NOP, K_ALU, K_LOAD, K_STORE, K_BRANCH, K_HALT} kind_e;

  localparam logic [31:0] NOP_IR = {OP_NOP, 26'd0};

  logic [31:0] Mem [0:1023];
  logic [31:0] Reg [0:31];

  logic [31:0] ifid_ir;
  logic [9:0]  ifid_npc;

  kind_e       idex_kind;
  opcode_e     idex_op;
  logic [9:0]  idex_npc;
  logic [31:0] idex_a, idex_b, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_dst;

  kind_e       exmem_kind;
  logic [31:0] exmem_alu, exmem_b;
  logic [4:0]  exmem_dst;

  kind_e       memwb_kind;
  logic [31:0] memwb_res;
  logic [4:0]  memwb_dst;

  logic [4:0]  id_rs, id_rt;
  kind_e       id_kind;
  logic [4:0]  id_dst;
  logic [31:0] id_a, id_b;
  logic        wb_wr, exmem_fwd, freeze, taken;
  logic [31:0] fa, fb, alu;
  logic [9:0]  target;

  assign id_rs     = ifid_ir[25:21];
  assign id_rt     = ifid_ir[20:16];
  assign wb_wr     = (memwb_kind == K_ALU || memwb_kind == K_LOAD) && memwb_dst != 5'd0;
  assign exmem_fwd = (exmem_kind == K_ALU) && exmem_dst != 5'd0;
  assign freeze    = halted || memwb_kind == K_HALT;

  always_comb begin
    id_kind = K_NOP;
    id_dst  = ifid_ir[15:11];
    case (opcode_e'(ifid_ir[31:26]))
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: id_kind = K_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI: begin id_kind = K_ALU;  id_dst = id_rt; end
      OP_LW:                     begin id_kind = K_LOAD; id_dst = id_rt; end
      OP_SW:                     id_kind = K_STORE;
      OP_BNEQZ, OP_BEQZ:         id_kind = K_BRANCH;
      OP_HLT:                    id_kind = K_HALT;
      default:                   id_kind = K_NOP;
    endcase
  end

  // Write-through read: the value retiring in WB this cycle wins over the array.
  always_comb begin
    id_a = Reg[id_rs];
    id_b = Reg[id_rt];
    if (id_rs == 5'd0)                        id_a = '0;
    else if (wb_wr && memwb_dst == id_rs)     id_a = memwb_res;
    if (id_rt == 5'd0)                        id_b = '0;
    else if (wb_wr && memwb_dst == id_rt)     id_b = memwb_res;
  end

  // Load results exist only in MEM/WB, so EX/MEM forwards ALU results alone.
  always_comb begin
    fa = idex_a;
    fb = idex_b;
    if (exmem_fwd && exmem_dst == idex_rs)   fa = exmem_alu;
    else if (wb_wr && memwb_dst == idex_rs)  fa = memwb_res;
    if (exmem_fwd && exmem_dst == idex_rt)   fb = exmem_alu;
    else if (wb_wr && memwb_dst == idex_rt)  fb = memwb_res;
  end

  always_comb begin
    alu = fa + idex_imm;
    case (idex_op)
      OP_ADD:  alu = fa + fb;
      OP_SUB:  alu = fa - fb;
      OP_AND:  alu = fa & fb;
      OP_OR:   alu = fa | fb;
      OP_SLT:  alu = {31'd0, $signed(fa) < $signed(fb)};
      OP_MUL:  alu = fa * fb;
      OP_SUBI: alu = fa - idex_imm;
      OP_SLTI: alu = {31'd0, $signed(fa) < $signed(idex_imm)};
      default: alu = fa + idex_imm;
    endcase
  end

  assign taken  = (idex_kind == K_BRANCH) && ((idex_op == OP_BEQZ) == (fa == 32'd0));
  assign target = idex_npc + idex_imm[9:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= '0;
      halted     <= 1'b0;
      ifid_ir    <= NOP_IR;
      ifid_npc   <= '0;
      idex_kind  <= K_NOP;
      idex_op    <= OP_NOP;
      idex_npc   <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
      idex_rs    <= '0;
      idex_rt    <= '0;
      idex_dst   <= '0;
      exmem_kind <= K_NOP;
      exmem_alu  <= '0;
      exmem_b    <= '0;
      exmem_dst  <= '0;
      memwb_kind <= K_NOP;
      memwb_res  <= '0;
      memwb_dst  <= '0;
    end else if (freeze) begin
      halted <= 1'b1;
    end else begin
      pc       <= taken ? target : pc + 10'd1;
      ifid_ir  <= taken ? NOP_IR : Mem[pc];
      ifid_npc <= pc + 10'd1;

      idex_kind <= taken ? K_NOP : id_kind;
      idex_op   <= taken ? OP_NOP : opcode_e'(ifid_ir[31:26]);
      idex_npc  <= ifid_npc;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_imm  <= {{16{ifid_ir[15]}}, ifid_ir[15:0]};
      idex_rs   <= id_rs;
      idex_rt   <= id_rt;
      idex_dst  <= id_dst;

      exmem_kind <= idex_kind;
      exmem_alu  <= alu;
      exmem_b    <= fb;
      exmem_dst  <= idex_dst;

      memwb_kind <= exmem_kind;
      memwb_res  <= (exmem_kind == K_LOAD) ? Mem[exmem_alu[9:0]] : exmem_alu;
      memwb_dst  <= exmem_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !freeze && exmem_kind == K_STORE)
      Mem[exmem_alu[9:0]] <= exmem_b;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !freeze && wb_wr)
      Reg[memwb_dst] <= memwb_res;
  end

endmodule

// File: tb/tb_pipe_mips.sv
// Directed bench for pipe_mips: programs are loaded into the core's arrays and results
// are checked against hand-computed register/memory values and halt timing.
module tb_pipe_mips;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halted;
  logic [9:0] pc;
  int checks = 0;
  int passes = 0;

  pipe_mips dut (.clk(clk), .rst_n(rst_n), .halted(halted), .pc(pc));

  always #5 clk = ~clk;

  localparam logic [31:0] HLT = 32'hfc000000;

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic start_load;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.Reg[i] = 32'(i);
  endtask

  task automatic release_reset;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int max, output int edge_idx);
    edge_idx = -1;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (halted === 1'b1) begin
        edge_idx = i;
        break;
      end
    end
  endtask

  task automatic load_sum;
    dut.Mem[0] = 32'h0ce77800; dut.Mem[1] = 32'h2801000f;
    dut.Mem[2] = 32'h28020014; dut.Mem[3] = 32'h28030019;
    dut.Mem[4] = 32'h0ce77800; dut.Mem[5] = 32'h0ce77800;
    dut.Mem[6] = 32'h00222000; dut.Mem[7] = 32'h0ce77800;
    dut.Mem[8] = 32'h00832800; dut.Mem[9] = 32'hfc000000;
  endtask

  task automatic test_reset;
    start_load;
    load_sum;
    checks++; if (pc !== 10'd0) $display("FAIL reset_pc: got %0d expected 0", pc); else passes++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else passes++;
    release_reset;
    @(posedge clk); #1;
    checks++; if (pc !== 10'd1) $display("FAIL first_fetch_pc: got %0d expected 1", pc); else passes++;
  endtask

  task automatic test_sum;
    int e;
    start_load;
    load_sum;
    release_reset;
    run_to_halt(100, e);
    checks++; if (e !== 13) $display("FAIL sum_halt_edge: got %0d expected 13", e); else passes++;
    checks++; if (dut.Reg[1] !== 32'd15) $display("FAIL sum_r1: got %0d expected 15", dut.Reg[1]); else passes++;
    checks++; if (dut.Reg[2] !== 32'd20) $display("FAIL sum_r2: got %0d expected 20", dut.Reg[2]); else passes++;
    checks++; if (dut.Reg[3] !== 32'd25) $display("FAIL sum_r3: got %0d expected 25", dut.Reg[3]); else passes++;
    checks++; if (dut.Reg[4] !== 32'd35) $display("FAIL sum_r4: got %0d expected 35", dut.Reg[4]); else passes++;
    checks++; if (dut.Reg[5] !== 32'd60) $display("FAIL sum_r5: got %0d expected 60", dut.Reg[5]); else passes++;
    checks++; if (dut.Reg[7] !== 32'd7) $display("FAIL sum_r7: got %0d expected 7", dut.Reg[7]); else passes++;
    checks++; if (dut.Reg[15] !== 32'd7) $display("FAIL sum_r15: got %0d expected 7", dut.Reg[15]); else passes++;
  endtask

  task automatic test_halt_freeze;
    logic [9:0]  pc0;
    logic [31:0] m9;
    pc0 = pc;
    m9  = dut.Mem[9];
    repeat (20) @(posedge clk);
    #1;
    checks++; if (pc !== pc0) $display("FAIL freeze_pc: got %0d expected %0d", pc, pc0); else passes++;
    checks++; if (halted !== 1'b1) $display("FAIL freeze_halted: got %b expected 1", halted); else passes++;
    checks++; if (dut.Reg[5] !== 32'd60) $display("FAIL freeze_r5: got %0d expected 60", dut.Reg[5]); else passes++;
    checks++; if (dut.Reg[0] !== 32'd0) $display("FAIL freeze_r0: got %0d expected 0", dut.Reg[0]); else passes++;
    checks++; if (dut.Mem[9] !== m9) $display("FAIL freeze_mem9: got %h expected %h", dut.Mem[9], m9); else passes++;
  endtask

  task automatic test_back_to_back;
    int e;
    start_load;
    dut.Mem[0] = i_ins(6'b001010, 5'd0, 5'd1, 16'd10);
    dut.Mem[1] = r_ins(6'b000000, 5'd1, 5'd1, 5'd2);
    dut.Mem[2] = r_ins(6'b000001, 5'd2, 5'd1, 5'd3);
    dut.Mem[3] = r_ins(6'b000101, 5'd3, 5'd2, 5'd4);
    dut.Mem[4] = HLT;
    release_reset;
    run_to_halt(100, e);
    checks++; if (e !== 8) $display("FAIL b2b_halt_edge: got %0d expected 8", e); else passes++;
    checks++; if (dut.Reg[2] !== 32'd20) $display("FAIL b2b_r2: got %0d expected 20", dut.Reg[2]); else passes++;
    checks++; if (dut.Reg[3] !== 32'd10) $display("FAIL b2b_r3: got %0d expected 10", dut.Reg[3]); else passes++;
    checks++; if (dut.Reg[4] !== 32'd200) $display("FAIL b2b_r4: got %0d expected 200", dut.Reg[4]); else passes++;
  endtask

  task automatic test_load_store;
    int e;
    start_load;
    dut.Mem[120] = 32'd85;
    dut.Mem[0] = i_ins(6'b001010, 5'd0, 5'd1, 16'd120);
    dut.Mem[1] = i_ins(6'b001000, 5'd1, 5'd2, 16'd0);
    dut.Mem[2] = 32'd0;
    dut.Mem[3] = i_ins(6'b001010, 5'd2, 5'd2, 16'd45);
    dut.Mem[4] = i_ins(6'b001001, 5'd1, 5'd2, 16'd1);
    dut.Mem[5] = HLT;
    release_reset;
    run_to_halt(100, e);
    checks++; if (e !== 9) $display("FAIL ls_halt_edge: got %0d expected 9", e); else passes++;
    checks++; if (dut.Mem[121] !== 32'd130) $display("FAIL ls_mem121: got %0d expected 130", dut.Mem[121]); else passes++;
    checks++; if (dut.Mem[120] !== 32'd85) $display("FAIL ls_mem120: got %0d expected 85", dut.Mem[120]); else passes++;
    checks++; if (dut.Reg[2] !== 32'd130) $display("FAIL ls_r2: got %0d expected 130", dut.Reg[2]); else passes++;
  endtask

  task automatic test_branch_flush;
    int e;
    start_load;
    dut.Mem[0] = i_ins(6'b001110, 5'd0, 5'd0, 16'd2);
    dut.Mem[1] = i_ins(6'b001010, 5'd0, 5'd6, 16'd99);
    dut.Mem[2] = i_ins(6'b001010, 5'd0, 5'd6, 16'd77);
    dut.Mem[3] = i_ins(6'b001010, 5'd0, 5'd8, 16'd5);
    dut.Mem[4] = HLT;
    release_reset;
    run_to_halt(100, e);
    checks++; if (e !== 8) $display("FAIL br_halt_edge: got %0d expected 8", e); else passes++;
    checks++; if (dut.Reg[6] !== 32'd6) $display("FAIL br_r6: got %0d expected 6", dut.Reg[6]); else passes++;
    checks++; if (dut.Reg[8] !== 32'd5) $display("FAIL br_r8: got %0d expected 5", dut.Reg[8]); else passes++;
  endtask

  task automatic test_factorial;
    int e;
    start_load;
    dut.Mem[200] = 32'd7;
    dut.Mem[0] = i_ins(6'b001010, 5'd0, 5'd10, 16'd200);
    dut.Mem[1] = i_ins(6'b001010, 5'd0, 5'd2, 16'd1);
    dut.Mem[2] = i_ins(6'b001000, 5'd10, 5'd3, 16'd0);
    dut.Mem[3] = 32'd0;
    dut.Mem[4] = r_ins(6'b000101, 5'd2, 5'd3, 5'd2);
    dut.Mem[5] = i_ins(6'b001011, 5'd3, 5'd3, 16'd1);
    dut.Mem[6] = i_ins(6'b001101, 5'd3, 5'd0, 16'hfffd);
    dut.Mem[7] = i_ins(6'b001001, 5'd10, 5'd2, 16'hfffe);
    dut.Mem[8] = HLT;
    release_reset;
    run_to_halt(500, e);
    checks++; if (halted !== 1'b1) $display("FAIL fact_halted: got %b expected 1", halted); else passes++;
    checks++; if (dut.Mem[198] !== 32'd5040) $display("FAIL fact_mem198: got %0d expected 5040", dut.Mem[198]); else passes++;
    checks++; if (dut.Reg[3] !== 32'd0) $display("FAIL fact_r3: got %0d expected 0", dut.Reg[3]); else passes++;
  endtask

  task automatic test_reset_midrun;
    int e;
    start_load;
    load_sum;
    release_reset;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (dut.Reg[2] !== 32'd20) $display("FAIL mid_r2_before: got %0d expected 20", dut.Reg[2]); else passes++;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (pc !== 10'd0) $display("FAIL mid_pc: got %0d expected 0", pc); else passes++;
    checks++; if (dut.Reg[3] !== 32'd3) $display("FAIL mid_r3_aborted: got %0d expected 3", dut.Reg[3]); else passes++;
    checks++; if (dut.Reg[1] !== 32'd15) $display("FAIL mid_r1_kept: got %0d expected 15", dut.Reg[1]); else passes++;
    release_reset;
    run_to_halt(100, e);
    checks++; if (e !== 13) $display("FAIL mid_halt_edge: got %0d expected 13", e); else passes++;
    checks++; if (dut.Reg[5] !== 32'd60) $display("FAIL mid_r5: got %0d expected 60", dut.Reg[5]); else passes++;
  endtask

  initial begin
    test_reset;
    test_sum;
    test_halt_freeze;
    test_back_to_back;
    test_load_store;
    test_branch_flush;
    test_factorial;
    test_reset_midrun;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
